// File: rtl/controller_pkg.sv
// controller_pkg
//   Definitions shared by the controller-port blocks. controller_responder_m
//   and controller_interface_m both use them.
//   - ctrl_state_e     : FSM states of the device-side responder
//   - CTRL_NUM_BUTTONS : default length of the button shift register
//   - BTN_*            : bit index of each button in a read frame
//                        (bit 0 is shifted out first)
package controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } ctrl_state_e;

   localparam int CTRL_NUM_BUTTONS = 8;

   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/sync_edge_m.sv
// sync_edge_m
//   Brings one asynchronous input into the clk domain. A 2-flop synchroniser
//   is followed by one more register, which allows single-cycle edge pulses.
//   Ports:
//     clk, rst  : clock and asynchronous active-high reset
//     d_i       : asynchronous input
//     level_o   : synchronised level
//     rise_o    : one-clk pulse on a synchronised 0->1 transition
//     fall_o    : one-clk pulse on a synchronised 1->0 transition
module sync_edge_m (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic s1_q, s2_q, s3_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign level_o = s2_q;
   assign rise_o  = s2_q & ~s3_q;
   assign fall_o  = ~s2_q & s3_q;

endmodule

// File: rtl/controller_responder_m.sv
// controller_responder_m
//   This block is the device-side end of the serial controller protocol. It
//   emulates an 8-button shift-register gamepad. The console's latch and
//   controller clock are oversampled in the local clk domain, so clk must run
//   at least 8x the controller clock.
//   Ports:
//     clk, rst              : system clock, asynchronous active-high reset
//     buttons               : pressed = 1, bit 0 shifted first (async)
//     controller_clk_in     : console controller clock (async)
//     controller_latch      : console latch, active high (async)
//     controller_data_out_B : serial data, active low (0 = pressed)
//     turbo_mask            : per-button turbo enable (turbo build only)
//     busy                  : high in LOAD or SHIFT
//     frame_done            : one-clk pulse when the last bit of a frame shifts
//     bits_shifted          : shifts since latch fell, saturates at NUM_BUTTONS
//   Optional feature: define CONTROLLER_RESPONDER_TURBO_EN to enable turbo.
//   In the turbo build, masked buttons read as released on alternate groups
//   of TURBO_PERIOD frames.
module controller_responder_m
   import controller_pkg::*;
#(
   parameter int NUM_BUTTONS   = CTRL_NUM_BUTTONS,
   parameter bit SHIFT_ON_RISE = 1'b1,
   parameter int TURBO_PERIOD  = 4,
   localparam int CW           = $clog2(NUM_BUTTONS + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_BUTTONS-1:0] buttons,
   input  logic                   controller_clk_in,
   input  logic                   controller_latch,
   output logic                   controller_data_out_B,
   input  logic [NUM_BUTTONS-1:0] turbo_mask,
   output logic                   busy,
   output logic                   frame_done,
   output logic [CW-1:0]          bits_shifted
);

   logic clk_rise, clk_fall, unused_clk_lvl;
   logic latch_lvl, unused_latch_rise, unused_latch_fall;
   logic shift_edge;

   sync_edge_m u_clk_sync (
      .clk     (clk),
      .rst     (rst),
      .d_i     (controller_clk_in),
      .level_o (unused_clk_lvl),
      .rise_o  (clk_rise),
      .fall_o  (clk_fall)
   );

   sync_edge_m u_latch_sync (
      .clk     (clk),
      .rst     (rst),
      .d_i     (controller_latch),
      .level_o (latch_lvl),
      .rise_o  (unused_latch_rise),
      .fall_o  (unused_latch_fall)
   );

   assign shift_edge = SHIFT_ON_RISE ? clk_rise : clk_fall;

   logic [NUM_BUTTONS-1:0] btn_s1_q, btn_s2_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_s1_q <= '0;
         btn_s2_q <= '0;
      end else begin
         btn_s1_q <= buttons;
         btn_s2_q <= btn_s1_q;
      end
   end

   ctrl_state_e            state_q;
   logic [NUM_BUTTONS-1:0] shreg_q;
   logic [NUM_BUTTONS-1:0] load_val;
   logic [CW-1:0]          cnt_q;
   logic                   busy_q, frame_done_q, out_q;

   // A latch fall is seen as the first clk in LOAD with the latch low.
   logic latch_fell;
   assign latch_fell = (state_q == ST_LOAD) && !latch_lvl;

`ifdef CONTROLLER_RESPONDER_TURBO_EN
   localparam int TW = $clog2(TURBO_PERIOD + 1);
   logic [TW-1:0] frame_q;
   logic          turbo_phase_q;

   // The phase toggles after every TURBO_PERIOD completed latches. The new
   // phase takes effect on the next load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_q       <= '0;
         turbo_phase_q <= 1'b0;
      end else if (latch_fell) begin
         if (frame_q == TW'(TURBO_PERIOD - 1)) begin
            frame_q       <= '0;
            turbo_phase_q <= ~turbo_phase_q;
         end else begin
            frame_q <= frame_q + 1'b1;
         end
      end
   end

   assign load_val = btn_s2_q & ~(turbo_mask & {NUM_BUTTONS{turbo_phase_q}});
`else
   logic unused_turbo;
   assign unused_turbo = ^turbo_mask;
   assign load_val     = btn_s2_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         shreg_q      <= '0;
         cnt_q        <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         out_q        <= 1'b1;
      end else begin
         frame_done_q <= 1'b0;
         out_q        <= ~shreg_q[0];
         // The latch overrides everything. It also abandons a partial frame
         // without a frame_done pulse.
         if (latch_lvl) begin
            state_q <= ST_LOAD;
            shreg_q <= load_val;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
         end else begin
            case (state_q)
               ST_IDLE: ;
               ST_LOAD: begin
                  state_q <= ST_SHIFT;
                  busy_q  <= 1'b1;
               end
               ST_SHIFT: begin
                  if (shift_edge) begin
                     shreg_q <= {1'b0, shreg_q[NUM_BUTTONS-1:1]};
                     cnt_q   <= cnt_q + 1'b1;
                     if (cnt_q == CW'(NUM_BUTTONS - 1)) begin
                        state_q      <= ST_DONE;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                     end
                  end
               end
               ST_DONE: begin
                  // Over-reads shift in zeros, so the line reads as released.
                  if (shift_edge)
                     shreg_q <= {1'b0, shreg_q[NUM_BUTTONS-1:1]};
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign controller_data_out_B = out_q;
   assign busy                  = busy_q;
   assign frame_done            = frame_done_q;
   assign bits_shifted          = cnt_q;

endmodule

// File: tb/tb_controller_responder_m.sv
module tb_controller_responder_m;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] buttons = 8'h00;
   logic       cclk = 1'b0;
   logic       latch = 1'b0;
   logic [7:0] turbo_mask = 8'h00;
   logic       data_b, busy, frame_done;
   logic [3:0] bits_shifted;

   int checks = 0;
   int failures = 0;
   int fd_cnt = 0;

   controller_responder_m dut (
      .clk                   (clk),
      .rst                   (rst),
      .buttons               (buttons),
      .controller_clk_in     (cclk),
      .controller_latch      (latch),
      .controller_data_out_B (data_b),
      .turbo_mask            (turbo_mask),
      .busy                  (busy),
      .frame_done            (frame_done),
      .bits_shifted          (bits_shifted)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_latch();
      latch = 1'b1;
      wait_clks(4);
      latch = 1'b0;
      wait_clks(6);
   endtask

   task automatic do_pulse();
      cclk = 1'b1;
      wait_clks(6);
      cclk = 1'b0;
      wait_clks(6);
   endtask

   task automatic test_reset();
      wait_clks(2);
      checks++; if (data_b !== 1'b1) begin failures++; $display("FAIL reset_data got=%b exp=1", data_b); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
      checks++; if (bits_shifted !== 4'd0) begin failures++; $display("FAIL reset_bits got=%0d exp=0", bits_shifted); end
      rst = 1'b0;
      wait_clks(2);
   endtask

   task automatic test_idle_edge();
      do_pulse();
      checks++; if (data_b !== 1'b1) begin failures++; $display("FAIL idle_edge_data got=%b exp=1", data_b); end
      checks++; if (bits_shifted !== 4'd0) begin failures++; $display("FAIL idle_edge_bits got=%0d exp=0", bits_shifted); end
   endtask

   task automatic test_basic_frame();
      logic [7:0] exp_seq;
      int fd0;
      exp_seq = 8'b0111_1010;  // reads 0,1,0,1,1,1,1,0 with read 0 in bit 0
      buttons = 8'b1000_0101;
      wait_clks(4);
      fd0 = fd_cnt;
      do_latch();
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
      for (int i = 0; i < 8; i++) begin
         if (i > 0) do_pulse();
         checks++; if (data_b !== exp_seq[i]) begin failures++; $display("FAIL basic_bit%0d got=%b exp=%b", i, data_b, exp_seq[i]); end
      end
      checks++; if (bits_shifted !== 4'd7) begin failures++; $display("FAIL basic_bits7 got=%0d exp=7", bits_shifted); end
      checks++; if (fd_cnt - fd0 != 0) begin failures++; $display("FAIL basic_fd_early got=%0d exp=0", fd_cnt - fd0); end
      do_pulse();
      checks++; if (fd_cnt - fd0 != 1) begin failures++; $display("FAIL basic_fd got=%0d exp=1", fd_cnt - fd0); end
      checks++; if (bits_shifted !== 4'd8) begin failures++; $display("FAIL basic_bits8 got=%0d exp=8", bits_shifted); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_done got=%b exp=0", busy); end
   endtask

   task automatic test_over_read();
      int fd0;
      buttons = 8'hFF;
      wait_clks(4);
      fd0 = fd_cnt;
      do_latch();
      for (int i = 0; i < 13; i++) begin
         if (i > 0) do_pulse();
         checks++; if (data_b !== (i >= 8)) begin failures++; $display("FAIL over_read%0d got=%b exp=%b", i, data_b, (i >= 8)); end
      end
      checks++; if (bits_shifted !== 4'd8) begin failures++; $display("FAIL over_bits got=%0d exp=8", bits_shifted); end
      checks++; if (fd_cnt - fd0 != 1) begin failures++; $display("FAIL over_fd got=%0d exp=1", fd_cnt - fd0); end
   endtask

   task automatic test_relatch();
      int fd0;
      buttons = 8'hFF;
      wait_clks(4);
      fd0 = fd_cnt;
      do_latch();
      repeat (3) do_pulse();
      checks++; if (bits_shifted !== 4'd3) begin failures++; $display("FAIL relatch_bits3 got=%0d exp=3", bits_shifted); end
      buttons = 8'h00;
      wait_clks(4);
      do_latch();
      checks++; if (bits_shifted !== 4'd0) begin failures++; $display("FAIL relatch_bits0 got=%0d exp=0", bits_shifted); end
      for (int i = 0; i < 8; i++) begin
         if (i > 0) do_pulse();
         checks++; if (data_b !== 1'b1) begin failures++; $display("FAIL relatch_bit%0d got=%b exp=1", i, data_b); end
      end
      checks++; if (fd_cnt - fd0 != 0) begin failures++; $display("FAIL relatch_fd got=%0d exp=0", fd_cnt - fd0); end
   endtask

   task automatic test_collision();
      buttons = 8'hA5;
      wait_clks(4);
      do_latch();
      repeat (2) do_pulse();
      checks++; if (bits_shifted !== 4'd2) begin failures++; $display("FAIL coll_bits2 got=%0d exp=2", bits_shifted); end
      cclk  = 1'b1;
      latch = 1'b1;
      wait_clks(4);
      cclk = 1'b0;
      wait_clks(2);
      latch = 1'b0;
      wait_clks(6);
      checks++; if (bits_shifted !== 4'd0) begin failures++; $display("FAIL coll_bits0 got=%0d exp=0", bits_shifted); end
      checks++; if (data_b !== 1'b0) begin failures++; $display("FAIL coll_bit0 got=%b exp=0", data_b); end
      do_pulse();
      checks++; if (data_b !== 1'b1) begin failures++; $display("FAIL coll_bit1 got=%b exp=1", data_b); end
      checks++; if (bits_shifted !== 4'd1) begin failures++; $display("FAIL coll_bits1 got=%0d exp=1", bits_shifted); end
   endtask

   task automatic test_async_reset();
      logic [7:0] exp_seq;
      int fd0;
      buttons = 8'hFF;
      wait_clks(4);
      do_latch();
      repeat (5) do_pulse();
      checks++; if (data_b !== 1'b0) begin failures++; $display("FAIL arst_pre got=%b exp=0", data_b); end
      #2 rst = 1'b1;
      #1;
      checks++; if (data_b !== 1'b1) begin failures++; $display("FAIL arst_data got=%b exp=1", data_b); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", busy); end
      checks++; if (bits_shifted !== 4'd0) begin failures++; $display("FAIL arst_bits got=%0d exp=0", bits_shifted); end
      wait_clks(2);
      rst = 1'b0;
      exp_seq = 8'hA5;  // ~8'h5A
      buttons = 8'h5A;
      wait_clks(4);
      fd0 = fd_cnt;
      do_latch();
      for (int i = 0; i < 8; i++) begin
         if (i > 0) do_pulse();
         checks++; if (data_b !== exp_seq[i]) begin failures++; $display("FAIL arst_bit%0d got=%b exp=%b", i, data_b, exp_seq[i]); end
      end
      do_pulse();
      checks++; if (fd_cnt - fd0 != 1) begin failures++; $display("FAIL arst_fd got=%0d exp=1", fd_cnt - fd0); end
   endtask

`ifdef CONTROLLER_RESPONDER_TURBO_EN
   task automatic test_turbo();
      // Earlier frames have already advanced the frame counter, so this
      // test starts from a clean reset.
      rst = 1'b1;
      wait_clks(2);
      rst = 1'b0;
      turbo_mask = 8'h01;
      buttons    = 8'h03;
      wait_clks(4);
      for (int f = 0; f < 12; f++) begin
         do_latch();
         checks++; if (data_b !== ((f / 4) % 2 == 1)) begin failures++; $display("FAIL turbo_f%0d_a got=%b exp=%b", f, data_b, ((f / 4) % 2 == 1)); end
         do_pulse();
         checks++; if (data_b !== 1'b0) begin failures++; $display("FAIL turbo_f%0d_b got=%b exp=0", f, data_b); end
      end
      turbo_mask = 8'h00;
   endtask
`endif

   initial begin
      test_reset();
      test_idle_edge();
      test_basic_frame();
      test_over_read();
      test_relatch();
      test_collision();
      test_async_reset();
`ifdef CONTROLLER_RESPONDER_TURBO_EN
      test_turbo();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/controller_responder_m.md
Name: controller_responder_m

Overview:
- Device-side end of the serial controller protocol: emulates a standard 8-button shift-register gamepad.
- Samples the console's controller_latch and controller clock, loads the button state, and shifts it out serially on an active-low data line.
- Used as a bench/board stand-in for physical pads, and for driving controller_1/2_data_in_B from an FPGA-attached input source.
- Runs entirely in its own clk domain; latch and controller clock are oversampled (clk must be ≥ 8× the controller clock).

Parameters:
- NUM_BUTTONS, 8: shift-register length; bits per read frame.
- SHIFT_ON_RISE, 1: 1 = advance on controller-clock rising edge; 0 = falling edge.
- TURBO_PERIOD, 4: latch frames per turbo half-cycle (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- buttons  input  NUM_BUTTONS  pressed = 1; bit 0 is shifted out first; asynchronous to clk.
- controller_clk_in  input  1  console controller clock; asynchronous.
- controller_latch  input  1  console latch, active high; asynchronous.
- controller_data_out_B  output  1  serial data, active low (0 = pressed).
- turbo_mask  input  NUM_BUTTONS  per-button turbo enable; ignored without the macro.
- busy  output  1  high in LOAD or SHIFT state.
- frame_done  output  1  one-clk pulse when the NUM_BUTTONS-th shift completes.
- bits_shifted  output  $clog2(NUM_BUTTONS+1)  shifts since the latch fell; saturates at NUM_BUTTONS.

Behaviour:
- Input synchronisers:
  - controller_clk_in, controller_latch and buttons each pass through a 2-flop synchroniser.
  - A third register on clock and latch provides edge detection.
- Reset (async assert, sync-safe deassert): all outputs and state clear.
  - shreg = 0, state = IDLE, bits_shifted = 0, busy = 0, frame_done = 0, controller_data_out_B = 1, turbo phase = 0.
- Serial output: controller_data_out_B = ~shreg[0] at all times (registered).
- States:
  - IDLE: on synced latch high -> LOAD.
  - LOAD: shreg <= synced buttons every clk while latch is high; bits_shifted <= 0. On latch fall -> SHIFT (shreg frozen at last loaded value).
  - SHIFT: on each active controller-clock edge (per SHIFT_ON_RISE), shreg <= {1'b0, shreg[N-1:1]} and bits_shifted++. When bits_shifted reaches NUM_BUTTONS: pulse frame_done and go -> DONE.
  - DONE: further clock edges shift in 0s (line stays high, reads as released); bits_shifted holds at NUM_BUTTONS; busy = 0. Latch high -> LOAD.
- Latch precedence: latch high in any state -> LOAD immediately; a simultaneous clock edge is ignored (load wins). This also covers re-latch mid-frame: the partial frame is abandoned with no frame_done pulse.
- Clock edge while in IDLE: no effect; line stays high.
- Latency: controller_data_out_B updates 4 clk after the physical controller-clock edge (2 sync + 1 edge + 1 output reg).
  - The console must sample no sooner than 4 clk + board delay after its own edge.
- Reset mid-frame: line goes high immediately (asynchronously) and state returns to IDLE.
- Edge-case rules:
  - A latch pulse shorter than 2 clk may be missed; this is a requirement on the console side.
  - Button changes during SHIFT do not affect the frame in flight.

Optional Feature:
- Macro: CONTROLLER_RESPONDER_TURBO_EN.
- Defined:
  - A frame counter increments on each latch fall and toggles turbo_phase every TURBO_PERIOD frames.
  - Loaded value = buttons & ~(turbo_mask & {NUM_BUTTONS{turbo_phase}}).
  - Reset clears the counter and phase.
- Undefined: loaded value = buttons; turbo_mask is unconnected internally; no counter logic is generated.

Decomposition:
- Shared package controller_pkg:
  - state enum (IDLE, LOAD, SHIFT, DONE);
  - NUM_BUTTONS default constant;
  - button bit-index constants (A=0, B=1, SELECT=2, START=3, UP=4, DOWN=5, LEFT=6, RIGHT=7), shared with controller_interface_m.
- One natural sub-module: sync_edge_m (2-flop synchroniser plus rise/fall pulse outputs), instantiated for the clock and latch inputs.

Test Plan:
- Basic frame: buttons = 8'b1000_0101, pulse latch, then 8 rising clocks -> data_out_B reads 0,1,0,1,1,1,1,0; frame_done pulses once after the 8th shift; bits_shifted = 8.
- Over-read: 12 clocks after latch, all buttons pressed -> first 8 bits low, bits 9-12 high; bits_shifted stays 8; no second frame_done.
- Re-latch mid-frame: buttons = 8'hFF, shift 3, latch again with buttons = 8'h00 -> no frame_done; next 8 bits all high; bits_shifted restarts at 0.
- Latch/edge collision: clock rising edge in the same clk as latch high -> shreg reloaded, no shift, bits_shifted = 0.
- Async reset during SHIFT after 5 bits -> data_out_B = 1 immediately, busy = 0, state IDLE; next latch/read returns a correct frame.
- TURBO_EN build: turbo_mask = 8'h01, A held, TURBO_PERIOD = 4 -> bit 0 reads pressed for 4 frames, released for 4, repeating; other bits unaffected.
